// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared types and constants for the unified-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

   // Which port is owed the read data returning from the RAM this cycle
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_DM   = 2'd2
   } owner_e;

   // Identity of a requesting port, used for the last-winner register
   typedef enum logic {
      PORT_IF = 1'b0,
      PORT_DM = 1'b1
   } port_e;

   localparam int POLICY_RR    = 0;
   localparam int POLICY_FIXED = 1;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Brief    : IF port, DM port and RAM port bundle of the memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
   parameter int XLen      = 32,
   parameter int AddrWidth = 10
);
   // Instruction-fetch port
   logic                   if_req_i;
   logic [AddrWidth-1:0]   if_addr_i;
   logic                   if_gnt_o;
   logic                   if_rvalid_o;
   logic [XLen-1:0]        if_rdata_o;
   // Data port
   logic                   dm_req_i;
   logic [AddrWidth-1:0]   dm_addr_i;
   logic                   dm_we_i;
   logic [XLen-1:0]        dm_wdata_i;
   logic                   dm_gnt_o;
   logic                   dm_rvalid_o;
   logic [XLen-1:0]        dm_rdata_o;
   // RAM port
   logic [AddrWidth-3:0]   mem_addr_o;
   logic                   mem_we_o;
   logic [XLen-1:0]        mem_wdata_o;
   logic [XLen-1:0]        mem_rdata_i;

   // Arbiter side
   modport slave (
      input  if_req_i, if_addr_i,
      output if_gnt_o, if_rvalid_o, if_rdata_o,
      input  dm_req_i, dm_addr_i, dm_we_i, dm_wdata_i,
      output dm_gnt_o, dm_rvalid_o, dm_rdata_o,
      output mem_addr_o, mem_we_o, mem_wdata_o,
      input  mem_rdata_i
   );

   // Core / RAM side
   modport master (
      output if_req_i, if_addr_i,
      input  if_gnt_o, if_rvalid_o, if_rdata_o,
      output dm_req_i, dm_addr_i, dm_we_i, dm_wdata_i,
      input  dm_gnt_o, dm_rvalid_o, dm_rdata_o,
      input  mem_addr_o, mem_we_o, mem_wdata_o,
      output mem_rdata_i
   );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Brief    : Two-requester grant logic (round-robin or fixed DM priority with
//            an IF starvation guard). Grants are combinational.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter2
   import mem_arb_pkg::*;
#(
   parameter int Policy  = POLICY_RR,
   parameter int MaxWait = 3
) (
   input  wire logic clk_i,
   input  wire logic rst_i,
   input  wire logic if_req_i,
   input  wire logic dm_req_i,
   output logic      if_gnt_o,
   output logic      dm_gnt_o
);
   localparam int                  c_WAIT_W   = (MaxWait < 1) ? 1 : $clog2(MaxWait + 1);
   localparam logic [c_WAIT_W-1:0] c_MAX_WAIT = c_WAIT_W'(MaxWait);

   port_e               r_last;
   logic [c_WAIT_W-1:0] r_wait;
   logic                w_if_win;

   // Decide whether IF wins this cycle; DM takes any remaining request
   always_comb begin
      w_if_win = 1'b0;
      if (if_req_i && !dm_req_i) begin
         w_if_win = 1'b1;
      end else if (if_req_i && dm_req_i) begin
         if (Policy == POLICY_RR) begin
            w_if_win = (r_last == PORT_DM);
         end else begin
            w_if_win = (r_wait == c_MAX_WAIT);
         end
      end
   end

   // No grant may escape while reset is held
   assign if_gnt_o = !rst_i && w_if_win;
   assign dm_gnt_o = !rst_i && dm_req_i && !w_if_win;

   // Track the last winner and how many times a pending IF has been denied
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_last <= PORT_DM;
         r_wait <= '0;
      end else begin
         if (if_gnt_o) begin
            r_last <= PORT_IF;
         end else if (dm_gnt_o) begin
            r_last <= PORT_DM;
         end
         if (if_req_i && !if_gnt_o) begin
            if (r_wait != c_MAX_WAIT) begin
               r_wait <= r_wait + 1'b1;
            end
         end else begin
            r_wait <= '0;
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Shares one synchronous-read word RAM between the IF and DM ports
//            and steers returning read data to the port that issued the read.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int XLen      = 32,
   parameter int AddrWidth = 10,
   parameter int Policy    = POLICY_RR,
   parameter int MaxWait   = 3
) (
   input  wire logic     clk_i,
   input  wire logic     rst_i,
   mem_arbiter_if.slave  bus
);
   localparam logic [XLen-1:0] c_ZERO_DATA = '0;

   logic   w_if_gnt;
   logic   w_dm_gnt;
   owner_e r_owner;
   logic   w_unused_addr_lsbs;

   rr_arbiter2 #(
      .Policy  (Policy),
      .MaxWait (MaxWait)
   ) u_arb (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .if_req_i (bus.if_req_i),
      .dm_req_i (bus.dm_req_i),
      .if_gnt_o (w_if_gnt),
      .dm_gnt_o (w_dm_gnt)
   );

   assign bus.if_gnt_o = w_if_gnt;
   assign bus.dm_gnt_o = w_dm_gnt;

   // Byte-lane bits are dropped: the RAM is word addressed and there is no trap
   assign w_unused_addr_lsbs = ^{bus.if_addr_i[1:0], bus.dm_addr_i[1:0]};

   // Route the winner onto the RAM port; idle cycles park the bus at zero
   always_comb begin
      bus.mem_addr_o  = '0;
      bus.mem_we_o    = 1'b0;
      bus.mem_wdata_o = c_ZERO_DATA;
      if (w_if_gnt) begin
         bus.mem_addr_o = bus.if_addr_i[AddrWidth-1:2];
      end else if (w_dm_gnt) begin
         bus.mem_addr_o = bus.dm_addr_i[AddrWidth-1:2];
         bus.mem_we_o   = bus.dm_we_i;
      end
      if (w_if_gnt || w_dm_gnt) begin
         bus.mem_wdata_o = bus.dm_wdata_i;
      end
   end

   // Remember who issued this cycle's read so next cycle's RAM data finds its owner
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_owner <= OWN_NONE;
      end else if (w_if_gnt) begin
         r_owner <= OWN_IF;
      end else if (w_dm_gnt && !bus.dm_we_i) begin
         r_owner <= OWN_DM;
      end else begin
         r_owner <= OWN_NONE;
      end
   end

   assign bus.if_rvalid_o = (r_owner == OWN_IF);
   assign bus.dm_rvalid_o = (r_owner == OWN_DM);
   assign bus.if_rdata_o  = (r_owner == OWN_IF) ? bus.mem_rdata_i : c_ZERO_DATA;
   assign bus.dm_rdata_o  = (r_owner == OWN_DM) ? bus.mem_rdata_i : c_ZERO_DATA;
endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Self-checking bench for mem_arbiter (round-robin and fixed
//            priority instances sharing one clock and reset).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   typedef struct {
      bit          is_if;
      logic [31:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic init_ram = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;

   exp_t        sb0[$];
   exp_t        sb1[$];
   logic [31:0] exp_mem [256];
   logic [31:0] ram0 [256];
   logic [31:0] ram1 [256];

   always #5 clk = ~clk;

   mem_arbiter_if #(.XLen(32), .AddrWidth(10)) bus0 ();
   mem_arbiter_if #(.XLen(32), .AddrWidth(10)) bus1 ();

   mem_arbiter #(.XLen(32), .AddrWidth(10), .Policy(POLICY_RR), .MaxWait(3)) u_rr (
      .clk_i (clk), .rst_i (rst), .bus (bus0));
   mem_arbiter #(.XLen(32), .AddrWidth(10), .Policy(POLICY_FIXED), .MaxWait(3)) u_fx (
      .clk_i (clk), .rst_i (rst), .bus (bus1));

   function automatic logic [31:0] seed(input int i);
      return (i == 4) ? 32'hDEADBEEF : (32'h1000_0000 + i);
   endfunction

   // Synchronous-read single-port RAMs behind each arbiter
   always @(posedge clk) begin
      if (init_ram) begin
         for (int i = 0; i < 256; i++) begin
            ram0[i] <= seed(i);
            ram1[i] <= seed(i);
         end
      end else begin
         if (bus0.mem_we_o) ram0[bus0.mem_addr_o] <= bus0.mem_wdata_o;
         if (bus1.mem_we_o) ram1[bus1.mem_addr_o] <= bus1.mem_wdata_o;
         bus0.mem_rdata_i <= ram0[bus0.mem_addr_o];
         bus1.mem_rdata_i <= ram1[bus1.mem_addr_o];
      end
   end

   task automatic clear_inputs();
      bus0.if_req_i = 0; bus0.if_addr_i = '0; bus0.dm_req_i = 0;
      bus0.dm_addr_i = '0; bus0.dm_we_i = 0; bus0.dm_wdata_i = '0;
      bus1.if_req_i = 0; bus1.if_addr_i = '0; bus1.dm_req_i = 0;
      bus1.dm_addr_i = '0; bus1.dm_we_i = 0; bus1.dm_wdata_i = '0;
   endtask

   task automatic apply_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      clear_inputs();
      @(posedge clk); #1;
      rst = 1'b0;
      sb0.delete();
      sb1.delete();
   endtask

   task automatic test_reset();
      bus0.if_req_i = 1; bus0.dm_req_i = 1;
      bus1.if_req_i = 1; bus1.dm_req_i = 1;
      @(negedge clk);
      n_checks++;
      if ({bus0.if_gnt_o, bus0.dm_gnt_o, bus0.if_rvalid_o, bus0.dm_rvalid_o, bus0.mem_we_o} !== 5'b0 ||
          bus0.if_rdata_o !== 32'h0 || bus0.dm_rdata_o !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_rr: gnt=%b%b rvalid=%b%b we=%b rdata=%h/%h, required all zero",
                  bus0.if_gnt_o, bus0.dm_gnt_o, bus0.if_rvalid_o, bus0.dm_rvalid_o,
                  bus0.mem_we_o, bus0.if_rdata_o, bus0.dm_rdata_o);
      end
      n_checks++;
      if ({bus1.if_gnt_o, bus1.dm_gnt_o, bus1.if_rvalid_o, bus1.dm_rvalid_o, bus1.mem_we_o} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_fixed: gnt=%b%b rvalid=%b%b we=%b, required all zero",
                  bus1.if_gnt_o, bus1.dm_gnt_o, bus1.if_rvalid_o, bus1.dm_rvalid_o, bus1.mem_we_o);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus0.if_gnt_o !== 1'b1 || bus0.dm_gnt_o !== 1'b0) begin
         n_fail++;
         $display("FAIL first_conflict: if_gnt=%b dm_gnt=%b, required if_gnt=1 dm_gnt=0",
                  bus0.if_gnt_o, bus0.dm_gnt_o);
      end
      @(posedge clk); #1;
      clear_inputs();
   endtask

   task automatic test_single_read();
      exp_t e;
      apply_reset();
      bus0.if_req_i = 1; bus0.if_addr_i = 10'h010;
      @(negedge clk);
      n_checks++;
      if (bus0.if_gnt_o !== 1'b1 || bus0.dm_gnt_o !== 1'b0 || bus0.mem_addr_o !== 8'd4) begin
         n_fail++;
         $display("FAIL single_gnt: if_gnt=%b dm_gnt=%b mem_addr=%0d, required 1 0 4",
                  bus0.if_gnt_o, bus0.dm_gnt_o, bus0.mem_addr_o);
      end
      sb0.push_back('{is_if: 1'b1, data: exp_mem[4]});
      @(posedge clk); #1;
      bus0.if_req_i = 0;
      @(negedge clk);
      e = sb0.pop_front();
      n_checks++;
      if (bus0.if_rvalid_o !== 1'b1 || bus0.dm_rvalid_o !== 1'b0 ||
          bus0.if_rdata_o !== e.data || bus0.dm_rdata_o !== 32'h0) begin
         n_fail++;
         $display("FAIL single_return: if_rvalid=%b dm_rvalid=%b if_rdata=%h dm_rdata=%h, required 1 0 %h 0",
                  bus0.if_rvalid_o, bus0.dm_rvalid_o, bus0.if_rdata_o, bus0.dm_rdata_o, e.data);
      end
      n_checks++;
      if (bus0.mem_addr_o !== 8'd0 || bus0.mem_we_o !== 1'b0 || bus0.if_gnt_o !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_bus: mem_addr=%0d we=%b if_gnt=%b, required 0 0 0",
                  bus0.mem_addr_o, bus0.mem_we_o, bus0.if_gnt_o);
      end
      @(negedge clk);
      n_checks++;
      if (bus0.if_rvalid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL single_rvalid_pulse: if_rvalid=%b, required 0", bus0.if_rvalid_o);
      end
   endtask

   task automatic test_round_robin();
      exp_t e;
      bit   want_if;
      apply_reset();
      bus0.if_req_i = 1; bus0.if_addr_i = 10'h010;
      bus0.dm_req_i = 1; bus0.dm_addr_i = 10'h014; bus0.dm_we_i = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (sb0.size() > 0) begin
            e = sb0.pop_front();
            n_checks++;
            if ((e.is_if ? bus0.if_rvalid_o : bus0.dm_rvalid_o) !== 1'b1 ||
                (e.is_if ? bus0.dm_rvalid_o : bus0.if_rvalid_o) !== 1'b0 ||
                (e.is_if ? bus0.if_rdata_o : bus0.dm_rdata_o) !== e.data) begin
               n_fail++;
               $display("FAIL rr_return[%0d]: if_rvalid=%b dm_rvalid=%b if_rdata=%h dm_rdata=%h, required %s data %h",
                        i, bus0.if_rvalid_o, bus0.dm_rvalid_o, bus0.if_rdata_o, bus0.dm_rdata_o,
                        e.is_if ? "IF" : "DM", e.data);
            end
         end
         if (i < 4) begin
            want_if = (i % 2 == 0);
            n_checks++;
            if (bus0.if_gnt_o !== want_if || bus0.dm_gnt_o !== !want_if) begin
               n_fail++;
               $display("FAIL rr_grant[%0d]: if_gnt=%b dm_gnt=%b, required if_gnt=%b dm_gnt=%b",
                        i, bus0.if_gnt_o, bus0.dm_gnt_o, want_if, !want_if);
            end
            sb0.push_back('{is_if: want_if, data: exp_mem[want_if ? 4 : 5]});
         end
         @(posedge clk); #1;
         if (i == 3) clear_inputs();
      end
   endtask

   task automatic test_fixed_priority();
      exp_t e;
      bit   want_if;
      int   model_wait = 0;
      apply_reset();
      bus1.if_req_i = 1; bus1.if_addr_i = 10'h018;
      bus1.dm_req_i = 1; bus1.dm_addr_i = 10'h01C; bus1.dm_we_i = 0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         if (sb1.size() > 0) begin
            e = sb1.pop_front();
            n_checks++;
            if ((e.is_if ? bus1.if_rvalid_o : bus1.dm_rvalid_o) !== 1'b1 ||
                (e.is_if ? bus1.dm_rvalid_o : bus1.if_rvalid_o) !== 1'b0 ||
                (e.is_if ? bus1.if_rdata_o : bus1.dm_rdata_o) !== e.data) begin
               n_fail++;
               $display("FAIL fixed_return[%0d]: if_rvalid=%b dm_rvalid=%b if_rdata=%h dm_rdata=%h, required %s data %h",
                        i, bus1.if_rvalid_o, bus1.dm_rvalid_o, bus1.if_rdata_o, bus1.dm_rdata_o,
                        e.is_if ? "IF" : "DM", e.data);
            end
         end
         if (i < 8) begin
            want_if = (model_wait == 3);
            model_wait = want_if ? 0 : model_wait + 1;
            n_checks++;
            if (bus1.if_gnt_o !== want_if || bus1.dm_gnt_o !== !want_if) begin
               n_fail++;
               $display("FAIL fixed_grant[%0d]: if_gnt=%b dm_gnt=%b, required if_gnt=%b dm_gnt=%b",
                        i, bus1.if_gnt_o, bus1.dm_gnt_o, want_if, !want_if);
            end
            sb1.push_back('{is_if: want_if, data: exp_mem[want_if ? 6 : 7]});
         end
         @(posedge clk); #1;
         if (i == 7) clear_inputs();
      end
   endtask

   task automatic test_write_then_read();
      exp_t e;
      apply_reset();
      bus0.dm_req_i = 1; bus0.dm_we_i = 1; bus0.dm_addr_i = 10'h020; bus0.dm_wdata_i = 32'hCAFEF00D;
      @(negedge clk);
      n_checks++;
      if (bus0.dm_gnt_o !== 1'b1 || bus0.mem_we_o !== 1'b1 || bus0.mem_addr_o !== 8'd8 ||
          bus0.mem_wdata_o !== 32'hCAFEF00D) begin
         n_fail++;
         $display("FAIL write_issue: dm_gnt=%b we=%b addr=%0d wdata=%h, required 1 1 8 cafef00d",
                  bus0.dm_gnt_o, bus0.mem_we_o, bus0.mem_addr_o, bus0.mem_wdata_o);
      end
      exp_mem[8] = 32'hCAFEF00D;
      @(posedge clk); #1;
      bus0.dm_req_i = 0; bus0.dm_we_i = 0;
      bus0.if_req_i = 1; bus0.if_addr_i = 10'h020;
      @(negedge clk);
      n_checks++;
      if (bus0.dm_rvalid_o !== 1'b0 || bus0.if_rvalid_o !== 1'b0 || bus0.if_gnt_o !== 1'b1 ||
          bus0.mem_we_o !== 1'b0) begin
         n_fail++;
         $display("FAIL write_no_return: dm_rvalid=%b if_rvalid=%b if_gnt=%b we=%b, required 0 0 1 0",
                  bus0.dm_rvalid_o, bus0.if_rvalid_o, bus0.if_gnt_o, bus0.mem_we_o);
      end
      sb0.push_back('{is_if: 1'b1, data: exp_mem[8]});
      @(posedge clk); #1;
      clear_inputs();
      @(negedge clk);
      e = sb0.pop_front();
      n_checks++;
      if (bus0.if_rvalid_o !== 1'b1 || bus0.if_rdata_o !== e.data) begin
         n_fail++;
         $display("FAIL read_after_write: if_rvalid=%b if_rdata=%h, required 1 %h",
                  bus0.if_rvalid_o, bus0.if_rdata_o, e.data);
      end
   endtask

   task automatic test_reset_mid();
      bit want_if;
      int model_wait = 0;
      apply_reset();
      bus1.if_req_i = 1; bus1.dm_req_i = 1;
      @(posedge clk); #1;
      bus0.if_req_i = 1; bus0.if_addr_i = 10'h010;
      @(negedge clk);
      n_checks++;
      if (bus0.if_gnt_o !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_gnt: if_gnt=%b, required 1", bus0.if_gnt_o);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      clear_inputs();
      @(negedge clk);
      n_checks++;
      if (bus0.if_rvalid_o !== 1'b0 || bus0.if_rdata_o !== 32'h0) begin
         n_fail++;
         $display("FAIL mid_drop: if_rvalid=%b if_rdata=%h, required 0 0",
                  bus0.if_rvalid_o, bus0.if_rdata_o);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      bus0.if_req_i = 1; bus0.dm_req_i = 1;
      bus1.if_req_i = 1; bus1.dm_req_i = 1;
      @(negedge clk);
      n_checks++;
      if (bus0.if_rvalid_o !== 1'b0 || bus0.if_gnt_o !== 1'b1 || bus0.dm_gnt_o !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_rr: if_rvalid=%b if_gnt=%b dm_gnt=%b, required 0 1 0",
                  bus0.if_rvalid_o, bus0.if_gnt_o, bus0.dm_gnt_o);
      end
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         want_if = (model_wait == 3);
         model_wait = want_if ? 0 : model_wait + 1;
         n_checks++;
         if (bus1.if_gnt_o !== want_if || bus1.dm_gnt_o !== !want_if) begin
            n_fail++;
            $display("FAIL post_reset_fixed[%0d]: if_gnt=%b dm_gnt=%b, required if_gnt=%b dm_gnt=%b",
                     i, bus1.if_gnt_o, bus1.dm_gnt_o, want_if, !want_if);
         end
         @(posedge clk); #1;
      end
      clear_inputs();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) exp_mem[i] = seed(i);
      rst = 1'b1;
      clear_inputs();
      @(posedge clk); #1;
      init_ram = 1'b0;
      test_reset();
      test_single_read();
      test_round_robin();
      test_fixed_priority();
      test_write_then_read();
      test_reset_mid();
      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
